// File: rtl/crc24_pkg.sv
// Shared definitions for the CRC-24 frame appender.
//   CRC24_POLY / CRC24_INIT : generator polynomial (implicit x^24) and per-frame seed
//   crc24_app_state_t       : appender FSM states
//   crc24_step()            : one byte of MSB-first CRC-24, no reflection, no final XOR
package crc24_pkg;

    localparam logic [23:0] CRC24_POLY = 24'h864CFB;
    localparam logic [23:0] CRC24_INIT = 24'h000000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PAYLOAD = 3'd1,
        ST_CRC_HI  = 3'd2,
        ST_CRC_MID = 3'd3,
        ST_CRC_LO  = 3'd4
    } crc24_app_state_t;

    function automatic logic [23:0] crc24_step(
        input logic [23:0] crc,
        input logic [7:0]  data,
        input logic [23:0] poly = CRC24_POLY
    );
        logic [23:0] c;
        logic [7:0]  d;
        logic        fb;
        c = crc;
        d = data;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = c[23] ^ d[7];
            c  = {c[22:0], 1'b0};
            d  = {d[6:0], 1'b0};
            if (fb) begin
                c = c ^ poly;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc24_byte_step.sv
// Combinational single-byte CRC-24 update.
//   crc_in  [23:0] : current CRC register
//   data_in [7:0]  : byte being absorbed (MSB first)
//   crc_out [23:0] : CRC after absorbing data_in
module crc24_byte_step
    import crc24_pkg::*;
#(
    parameter logic [23:0] POLY = CRC24_POLY
) (
    input  logic [23:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [23:0] crc_out
);

    always_comb begin
        crc_out = crc24_step(crc_in, data_in, POLY);
    end

endmodule

// File: rtl/crc24_frame_appender.sv
// Passes payload bytes through one register stage and appends the three CRC-24
// bytes (MSB first) after the last payload byte; the final CRC byte carries out_last.
// Ports:
//   clock                   : single clock, posedge
//   reset                   : synchronous, active-low
//   in_data/in_valid/in_last/in_ready      : payload stream in
//   out_data/out_valid/out_last/out_ready  : payload + CRC stream out
//   frame_count [15:0]      : completed frames (only with CRC_FRAME_STATS_EN defined)
// Build option: CRC_FRAME_STATS_EN adds the frame_count port and counter.
module crc24_frame_appender
    import crc24_pkg::*;
#(
    parameter logic [23:0] POLY = CRC24_POLY,
    parameter logic [23:0] INIT = CRC24_INIT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready
`ifdef CRC_FRAME_STATS_EN
    ,
    output logic [15:0] frame_count
`endif
);

    crc24_app_state_t state_q, state_d;
    logic [23:0] crc_q, crc_d, crc_step_out;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        free, in_ready_int, accept;

    crc24_byte_step #(.POLY(POLY)) u_byte_step (
        .crc_in  (crc_q),
        .data_in (in_data),
        .crc_out (crc_step_out)
    );

    // The output register can take a new byte when empty or being drained.
    always_comb begin
        free         = !out_valid_q || out_ready;
        in_ready_int = reset && free && (state_q == ST_IDLE || state_q == ST_PAYLOAD);
        accept       = in_valid && in_ready_int;
    end

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        // out_last only ever accompanies a valid byte.
        out_last_d  = out_last_q && out_valid_d;

        case (state_q)
            ST_IDLE, ST_PAYLOAD: begin
                if (accept) begin
                    out_data_d  = in_data;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    crc_d       = crc_step_out;
                    state_d     = in_last ? ST_CRC_HI : ST_PAYLOAD;
                end
            end
            ST_CRC_HI: begin
                if (free) begin
                    out_data_d  = crc_q[23:16];
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    state_d     = ST_CRC_MID;
                end
            end
            ST_CRC_MID: begin
                if (free) begin
                    out_data_d  = crc_q[15:8];
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    state_d     = ST_CRC_LO;
                end
            end
            ST_CRC_LO: begin
                if (free) begin
                    out_data_d  = crc_q[7:0];
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
                    crc_d       = INIT;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                crc_d   = INIT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            crc_q       <= INIT;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = in_ready_int;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

`ifdef CRC_FRAME_STATS_EN
    logic [15:0] frame_count_q, frame_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        if (out_valid_q && out_ready && out_last_q) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_crc24_frame_appender.sv
module tb_crc24_frame_appender;

    typedef logic [7:0] bytes_t[$];
    typedef bit         bits_t[$];

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready = 1'b1;
`ifdef CRC_FRAME_STATS_EN
    logic [15:0] frame_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int gap_max = 0;

    logic [8:0] out_q[$];
    logic [8:0] exp_q[$];
    int         drain_q[$];
    int         acc_cyc[$];

    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    crc24_frame_appender dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
`ifdef CRC_FRAME_STATS_EN
        ,
        .frame_count (frame_count)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            1:       out_ready = ~out_ready;
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
        endcase
    end

    // Output monitor: collects handshaken bytes and checks the holding rule.
    always @(negedge clock) begin
        if (prev_stall) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                miscompares++;
                $display("FAIL hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         out_valid, out_data, out_last, prev_data, prev_last);
            end
        end
        prev_stall = reset && out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        if (reset && out_valid && out_ready) begin
            out_q.push_back({out_last, out_data});
            if (out_last) drain_q.push_back(cyc);
        end
    end

    // Reference: polynomial long division of msg * x^24 by the 25-bit generator.
    function automatic logic [23:0] model_crc(input bytes_t msg);
        logic [24:0] rem;
        logic [7:0]  b;
        rem = '0;
        foreach (msg[i]) begin
            b = msg[i];
            for (int k = 7; k >= 0; k--) begin
                rem = {rem[23:0], b[k]};
                if (rem[24]) rem = rem ^ 25'h1864CFB;
            end
        end
        for (int k = 0; k < 24; k++) begin
            rem = {rem[23:0], 1'b0};
            if (rem[24]) rem = rem ^ 25'h1864CFB;
        end
        return rem[23:0];
    endfunction

    task automatic add_expected(input bytes_t msg);
        logic [23:0] c;
        c = model_crc(msg);
        foreach (msg[i]) exp_q.push_back({1'b0, msg[i]});
        exp_q.push_back({1'b0, c[23:16]});
        exp_q.push_back({1'b0, c[15:8]});
        exp_q.push_back({1'b1, c[7:0]});
    endtask

    task automatic clear_queues();
        out_q.delete();
        exp_q.delete();
        drain_q.delete();
        acc_cyc.delete();
    endtask

    task automatic drive(input bytes_t d, input bits_t l);
        for (int i = 0; i < d.size(); i++) begin
            int gap;
            int t;
            gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) begin @(posedge clock); #1; end
            end
            in_data  = d[i];
            in_last  = l[i];
            in_valid = 1'b1;
            t = 0;
            forever begin
                @(negedge clock);
                if (in_ready) break;
                t++;
                if (t > 200) break;
            end
            if (t > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL drive_timeout: got in_ready=0 want 1 (byte %0d)", i);
            end else begin
                acc_cyc.push_back(cyc);
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input bytes_t d);
        bits_t l;
        foreach (d[i]) l.push_back(i == d.size() - 1);
        add_expected(d);
        drive(d, l);
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while (out_q.size() < n && t < 500) begin
            @(negedge clock);
            t++;
        end
        if (out_q.size() < n) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_out: got %0d bytes want %0d", out_q.size(), n);
        end
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++;
        if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        vectors++;
        if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_single_byte();
        int low;
        clear_queues();
        rdy_mode = 0;
        send_frame('{8'h01});
        low = 0;
        forever begin
            @(negedge clock);
            if (in_ready) break;
            low++;
            if (low > 20) break;
        end
        vectors++;
        if (low != 3) begin miscompares++; $display("FAIL single_gap: got %0d low cycles want 3", low); end
        wait_out(exp_q.size());
        vectors++;
        if (exp_q.size() != 4 || exp_q[3] !== {1'b1, 8'hFB}) begin
            miscompares++; $display("FAIL single_model: got %h want 1fb", exp_q[exp_q.size()-1]);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL single_byte[%0d]: got %h want %h", i, (i < out_q.size()) ? out_q[i] : 9'h0, exp_q[i]);
            end
        end
    endtask

    task automatic test_zero_payload();
        clear_queues();
        rdy_mode = 0;
        send_frame('{8'h00, 8'h00});
        wait_out(exp_q.size());
        vectors++;
        if (out_q.size() != 5) begin miscompares++; $display("FAIL zero_count: got %0d want 5", out_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL zero_byte[%0d]: got %h want %h", i, (i < out_q.size()) ? out_q[i] : 9'h0, exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        clear_queues();
        rdy_mode = 1;
        send_frame('{8'h01});
        wait_out(exp_q.size());
        rdy_mode = 0;
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if (out_q.size() != exp_q.size()) begin
            miscompares++; $display("FAIL stall_count: got %0d want %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL stall_byte[%0d]: got %h want %h", i, (i < out_q.size()) ? out_q[i] : 9'h0, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        rdy_mode = 0;
        drive('{8'h5A, 8'hC3}, '{1'b0, 1'b0});
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid: got %b want 0", out_valid); end
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL midreset_ready: got %b want 0", in_ready); end
        @(posedge clock); #1;
        reset = 1'b1;
        clear_queues();
        send_frame('{8'h01});
        wait_out(exp_q.size());
        vectors++;
        if (out_q.size() != 4) begin miscompares++; $display("FAIL midreset_count: got %0d want 4", out_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL midreset_byte[%0d]: got %h want %h", i, (i < out_q.size()) ? out_q[i] : 9'h0, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        rdy_mode = 0;
        gap_max  = 0;
        add_expected('{8'h01});
        add_expected('{8'h00, 8'h01});
        drive('{8'h01, 8'h00, 8'h01}, '{1'b1, 1'b0, 1'b1});
        wait_out(exp_q.size());
        vectors++;
        if (acc_cyc.size() < 2 || drain_q.size() < 1 || acc_cyc[1] != drain_q[0]) begin
            miscompares++;
            $display("FAIL b2b_accept_cycle: got %0d want %0d",
                     (acc_cyc.size() > 1) ? acc_cyc[1] : -1, (drain_q.size() > 0) ? drain_q[0] : -1);
        end
        vectors++;
        if (acc_cyc.size() < 2 || acc_cyc[1] - acc_cyc[0] != 4) begin
            miscompares++;
            $display("FAIL b2b_gap: got %0d want 4", (acc_cyc.size() > 1) ? acc_cyc[1] - acc_cyc[0] : -1);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL b2b_byte[%0d]: got %h want %h", i, (i < out_q.size()) ? out_q[i] : 9'h0, exp_q[i]);
            end
        end
    endtask

    task automatic test_random_frames();
        clear_queues();
        rdy_mode = 2;
        gap_max  = 2;
        for (int f = 0; f < 8; f++) begin
            bytes_t d;
            int len;
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) d.push_back(8'($urandom));
            send_frame(d);
        end
        wait_out(exp_q.size());
        rdy_mode = 0;
        gap_max  = 0;
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if (out_q.size() != exp_q.size()) begin
            miscompares++; $display("FAIL random_count: got %0d want %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL random_byte[%0d]: got %h want %h", i, (i < out_q.size()) ? out_q[i] : 9'h0, exp_q[i]);
            end
        end
    endtask

`ifdef CRC_FRAME_STATS_EN
    task automatic test_frame_count();
        rdy_mode = 0;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        vectors++;
        if (frame_count !== 16'd0) begin miscompares++; $display("FAIL fc_reset: got %0d want 0", frame_count); end
        for (int f = 1; f <= 3; f++) begin
            clear_queues();
            send_frame('{8'($urandom), 8'($urandom)});
            wait_out(exp_q.size());
            vectors++;
            if (frame_count !== 16'(f)) begin miscompares++; $display("FAIL fc_step: got %0d want %0d", frame_count, f); end
        end
        force dut.frame_count_q = 16'hFFFF;
        @(posedge clock); #1;
        release dut.frame_count_q;
        @(negedge clock);
        vectors++;
        if (frame_count !== 16'hFFFF) begin miscompares++; $display("FAIL fc_preload: got %h want ffff", frame_count); end
        clear_queues();
        send_frame('{8'h01});
        wait_out(exp_q.size());
        vectors++;
        if (frame_count !== 16'd0) begin miscompares++; $display("FAIL fc_wrap: got %h want 0000", frame_count); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_zero_payload();
        test_stall();
        test_reset_midframe();
        test_back_to_back();
        test_random_frames();
`ifdef CRC_FRAME_STATS_EN
        test_frame_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
